// File: rtl/regfile_pkg.sv
// Shared CPU register-file definitions: select encoding (0 = none, k = reg k-1)
// and the decode helpers used by the write decode and both read ports.
package regfile_pkg;

  localparam int SEL_NONE = 0;

  // A select code is in range when it names a real register: 1..num_regs.
  function automatic logic sel_in_range(input int sel, input int num_regs);
    return (sel >= 1) && (sel <= num_regs);
  endfunction

  function automatic int sel_to_idx(input int sel);
    return sel - 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: captures the select, 1-cycle latency, write bypass.
// stall holds the outputs, but a write to the captured register still refreshes rd_data.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              wr_vld,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

  logic [SEL_W-1:0] cap;
  logic             sel_ok;
  logic             sel_none;
  logic             byp_hit;
  logic             hold_hit;

  assign sel_ok   = sel_in_range(32'(rd_sel), NUM_REGS);
  assign sel_none = (rd_sel == SEL_W'(SEL_NONE));
  assign byp_hit  = wr_vld && (wr_sel == rd_sel);
  // wr_vld already implies an in-range wr_sel, so a match also implies cap is in range.
  assign hold_hit = wr_vld && (cap != SEL_W'(SEL_NONE)) && (wr_sel == cap);

  // Read-select errors only count when the select is actually being sampled.
  assign rd_err = !stall && !sel_none && !sel_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (!stall) begin
      cap      <= rd_sel;
      rd_valid <= sel_ok;
      if (!sel_ok)
        rd_data <= '0;
      else if (byp_hit)
        rd_data <= wr_data;
      else
        rd_data <= reg_val;
    end else if (hold_hit) begin
      rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/regfile_read_pipe.sv
// NUM_REGS x DATA_W register file, one write port, two registered read ports (latency 1).
// stall freezes both read ports; writes always proceed and keep held operands coherent.
module regfile_read_pipe
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rda_sel,
  input  logic [SEL_W-1:0]  rdb_sel,
  output logic [DATA_W-1:0] rda_data,
  output logic [DATA_W-1:0] rdb_data,
  output logic              rda_valid,
  output logic              rdb_valid,
  output logic              sel_err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rda_reg;
  logic [DATA_W-1:0] rdb_reg;
  logic              wr_vld;
  logic              wr_err;
  logic              rda_err;
  logic              rdb_err;

  assign wr_vld = wr_en && sel_in_range(32'(wr_sel), NUM_REGS);
  assign wr_err = wr_en && (wr_sel != SEL_W'(SEL_NONE)) && !wr_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_vld) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (i == sel_to_idx(32'(wr_sel)))
          regs[i] <= wr_data;
    end
  end

  // Pre-write array values; out-of-range and "none" codes fall through to zero.
  always_comb begin
    rda_reg = '0;
    rdb_reg = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rda_sel) == 32'(i + 1))
        rda_reg = regs[i];
      if (32'(rdb_sel) == 32'(i + 1))
        rdb_reg = regs[i];
    end
  end

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .SEL_W   (SEL_W)
  ) u_port_a (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .rd_sel  (rda_sel),
    .reg_val (rda_reg),
    .wr_vld  (wr_vld),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_data (rda_data),
    .rd_valid(rda_valid),
    .rd_err  (rda_err)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .SEL_W   (SEL_W)
  ) u_port_b (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .rd_sel  (rdb_sel),
    .reg_val (rdb_reg),
    .wr_vld  (wr_vld),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rd_data (rdb_data),
    .rd_valid(rdb_valid),
    .rd_err  (rdb_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sel_err <= 1'b0;
    else
      sel_err <= wr_err || rda_err || rdb_err;
  end

endmodule

// File: tb/tb_regfile_read_pipe.sv
// Directed scoreboard bench for regfile_read_pipe (DATA_W=16, NUM_REGS=16).
module tb_regfile_read_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic [4:0]  rda_sel = '0;
  logic [4:0]  rdb_sel = '0;
  logic [15:0] rda_data, rdb_data;
  logic        rda_valid, rdb_valid, sel_err;

  regfile_read_pipe #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rda_sel  (rda_sel),
    .rdb_sel  (rdb_sel),
    .rda_data (rda_data),
    .rdb_data (rdb_data),
    .rda_valid(rda_valid),
    .rdb_valid(rdb_valid),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [15:0] ad;
    logic        av;
    logic [15:0] bd;
    logic        bv;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares all outputs.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_check: due cycle %0d, now %0d", mon_e.due, cyc);
      end else begin
        chk("rda_data", 32'(rda_data), 32'(mon_e.ad));
        chk("rda_valid", 32'(rda_valid), 32'(mon_e.av));
        chk("rdb_data", 32'(rdb_data), 32'(mon_e.bd));
        chk("rdb_valid", 32'(rdb_valid), 32'(mon_e.bv));
        chk("sel_err", 32'(sel_err), 32'(mon_e.err));
      end
    end
  end

  // Drive one cycle of inputs; optionally queue the outputs expected after the next edge.
  task automatic step(input logic st, input logic we, input logic [4:0] ws, input logic [15:0] wd,
                      input logic [4:0] as, input logic [4:0] bs, input logic en,
                      input logic [15:0] ad, input logic av, input logic [15:0] bd,
                      input logic bv, input logic er);
    exp_t e;
    stall   = st;
    wr_en   = we;
    wr_sel  = ws;
    wr_data = wd;
    rda_sel = as;
    rdb_sel = bs;
    if (en) begin
      e.due = cyc + 1;
      e.ad = ad; e.av = av; e.bd = bd; e.bv = bv; e.err = er;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rda_data"}, 32'(rda_data), 32'h0);
    chk({tag, "_rda_valid"}, 32'(rda_valid), 32'h0);
    chk({tag, "_rdb_data"}, 32'(rdb_data), 32'h0);
    chk({tag, "_rdb_valid"}, 32'(rdb_valid), 32'h0);
    chk({tag, "_sel_err"}, 32'(sel_err), 32'h0);
  endtask

  logic [15:0] tbl [16];

  initial begin
    #2;
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    //    st  we  wsel   wdata     a      b     chk  a_dat     av    b_dat     bv    err
    step(0, 0, 5'd0,  16'h0000, 5'd1,  5'd16, 1, 16'h0000, 1, 16'h0000, 1, 0);
    step(0, 1, 5'd4,  16'hBEEF, 5'd0,  5'd0,  1, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 0, 5'd0,  16'h0000, 5'd4,  5'd0,  1, 16'hBEEF, 1, 16'h0000, 0, 0);
    step(0, 1, 5'd5,  16'h5555, 5'd0,  5'd0,  1, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 1, 5'd5,  16'h1234, 5'd4,  5'd5,  1, 16'hBEEF, 1, 16'h1234, 1, 0);
    step(0, 0, 5'd0,  16'h0000, 5'd5,  5'd5,  1, 16'h1234, 1, 16'h1234, 1, 0);
    step(0, 1, 5'd2,  16'h0011, 5'd0,  5'd0,  1, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 0, 5'd0,  16'h0000, 5'd2,  5'd4,  1, 16'h0011, 1, 16'hBEEF, 1, 0);
    // Stalled: write to captured reg1 refreshes A; select changes ignored.
    step(1, 1, 5'd2,  16'h00AA, 5'd7,  5'd9,  1, 16'h00AA, 1, 16'hBEEF, 1, 0);
    step(1, 0, 5'd0,  16'h0000, 5'd3,  5'd0,  1, 16'h00AA, 1, 16'hBEEF, 1, 0);
    step(1, 0, 5'd0,  16'h0000, 5'd17, 5'd0,  1, 16'h00AA, 1, 16'hBEEF, 1, 0);
    step(1, 1, 5'd20, 16'hFFFF, 5'd0,  5'd0,  1, 16'h00AA, 1, 16'hBEEF, 1, 1);
    step(0, 0, 5'd0,  16'h0000, 5'd3,  5'd2,  1, 16'h0000, 1, 16'h00AA, 1, 0);
    // Out-of-range read select, then the pulse must drop.
    step(0, 0, 5'd0,  16'h0000, 5'd17, 5'd0,  1, 16'h0000, 0, 16'h0000, 0, 1);
    step(0, 0, 5'd0,  16'h0000, 5'd0,  5'd0,  1, 16'h0000, 0, 16'h0000, 0, 0);
    step(0, 1, 5'd20, 16'hFFFF, 5'd0,  5'd0,  1, 16'h0000, 0, 16'h0000, 0, 1);
    step(0, 1, 5'd0,  16'h7777, 5'd1,  5'd0,  1, 16'h0000, 1, 16'h0000, 0, 0);
    step(0, 1, 5'd16, 16'hCAFE, 5'd16, 5'd16, 1, 16'hCAFE, 1, 16'hCAFE, 1, 0);

    tbl = '{default: 16'h0000};
    tbl[1]  = 16'h00AA;
    tbl[3]  = 16'hBEEF;
    tbl[4]  = 16'h1234;
    tbl[15] = 16'hCAFE;
    for (int k = 1; k <= 16; k++)
      step(0, 0, 5'd0, 16'h0000, 5'(k), 5'(17 - k), 1, tbl[k - 1], 1, tbl[16 - k], 1, 0);

    // Hold a valid operand under stall, then reset mid-cycle with a write pending.
    step(0, 0, 5'd0, 16'h0000, 5'd2, 5'd0, 1, 16'h00AA, 1, 16'h0000, 0, 0);
    step(1, 0, 5'd0, 16'h0000, 5'd0, 5'd0, 1, 16'h00AA, 1, 16'h0000, 0, 0);
    @(negedge clk);
    #1;
    stall   = 1'b1;
    wr_en   = 1'b1;
    wr_sel  = 5'd2;
    wr_data = 16'h9999;
    #1;
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    stall = 1'b0;
    reset = 1'b0;

    for (int k = 1; k <= 16; k++)
      step(0, 0, 5'd0, 16'h0000, 5'(k), 5'(17 - k), 1, 16'h0000, 1, 16'h0000, 1, 0);
    step(0, 0, 5'd0, 16'h0000, 5'd0, 5'd0, 1, 16'h0000, 0, 16'h0000, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
